// File: rtl/bound_pkg.sv
// Shared types for the flasher bar controller: FSM state and ramp mode.
package bound_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } state_t;

  typedef enum logic {
    ONESHOT,
    BOUNCE
  } mode_t;

endpackage

// File: rtl/therm_decoder.sv
// Thermometer decoder: out[i] is set for every i below the binary input value.
module therm_decoder #(
  parameter int unsigned N_OUT = 32,
  parameter int unsigned IN_W  = 6
) (
  input  logic [IN_W-1:0]  in,
  output logic [N_OUT-1:0] out
);

  for (genvar g = 0; g < N_OUT; g++) begin : g_bit
    assign out[g] = (in > IN_W'(g));
  end

endmodule

// File: rtl/bound_ramp_ctrl.sv
// LED bar ramp controller: steps the bar level toward a commanded bound once per
// prescaled tick, either once (one-shot) or oscillating between 0 and the bound.
module bound_ramp_ctrl #(
  parameter int unsigned N_LEDS = 32,
  parameter int unsigned LVL_W  = $clog2(N_LEDS + 1),
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LVL_W-1:0]  cmd_target,
  input  logic              cmd_bounce,
  input  logic [DIV_W-1:0]  cmd_div,
  input  logic              abort,
  output logic [N_LEDS-1:0] leds,
  output logic [LVL_W-1:0]  level,
  output logic              busy,
  output logic              done
);
  import bound_pkg::*;

  localparam logic [LVL_W-1:0] MaxLvl = LVL_W'(N_LEDS);

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [LVL_W-1:0]   target_q, target_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               done_q, done_d;

  logic [LVL_W-1:0]   cmd_tgt;
  mode_t              cmd_mode;
  logic [LVL_W-1:0]   level_inc, level_dec, floor_lvl;
  logic               tick;

  assign cmd_tgt   = (cmd_target > MaxLvl) ? MaxLvl : cmd_target;
  // A bounce toward 0 has nothing to bounce between, so it runs as a one-shot.
  assign cmd_mode  = (cmd_bounce && (cmd_tgt != '0)) ? BOUNCE : ONESHOT;
  assign level_inc = level_q + LVL_W'(1);
  assign level_dec = level_q - LVL_W'(1);
  assign floor_lvl = (mode_q == BOUNCE) ? '0 : target_q;
  assign tick      = (cnt_q == div_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_tgt > level_q) begin
              state_d = UP;
            end else if (cmd_tgt < level_q) begin
              state_d = DOWN;
            end
          end
        end
        UP: begin
          if (tick && (level_inc == target_q)) begin
            state_d = (mode_q == BOUNCE) ? DOWN : IDLE;
          end
        end
        DOWN: begin
          if (tick && (level_dec == floor_lvl)) begin
            state_d = (mode_q == BOUNCE) ? UP : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    cmd_ready = (state_q == IDLE) && !abort;
    busy      = (state_q != IDLE);
  end

  // Datapath: command latch, prescaler, level counter and done pulse
  always_comb begin
    mode_d   = mode_q;
    target_d = target_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    done_d   = 1'b0;
    if (abort) begin
      cnt_d   = '0;
      level_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            mode_d   = cmd_mode;
            target_d = cmd_tgt;
            div_d    = cmd_div;
            cnt_d    = '0;
            done_d   = (cmd_tgt == level_q);
          end
        end
        UP: begin
          if (tick) begin
            cnt_d   = '0;
            level_d = level_inc;
            done_d  = (level_inc == target_q) && (mode_q == ONESHOT);
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        DOWN: begin
          if (tick) begin
            cnt_d   = '0;
            level_d = level_dec;
            done_d  = (level_dec == floor_lvl);
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= ONESHOT;
      target_q <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      target_q <= target_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      done_q   <= done_d;
    end
  end

  assign level = level_q;
  assign done  = done_q;

  therm_decoder #(
    .N_OUT (N_LEDS),
    .IN_W  (LVL_W)
  ) u_therm (
    .in  (level_q),
    .out (leds)
  );

endmodule

// File: tb/tb_bound_ramp_ctrl.sv
// Self-checking bench for bound_ramp_ctrl: directed scenarios plus random traffic
// compared every cycle against a step-schedule model of the bar.
module tb_bound_ramp_ctrl;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_target;
  logic        cmd_bounce;
  logic [15:0] cmd_div;
  logic        abort;
  logic [31:0] leds;
  logic [5:0]  level;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  bound_ramp_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_bounce (cmd_bounce),
    .cmd_div    (cmd_div),
    .abort      (abort),
    .leds       (leds),
    .level      (level),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bar(input int l);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = (i < l);
    return r;
  endfunction

  // Model: a ramp is a run of steps of +/-1, each taking 'period' cycles.
  int m_level = 0, m_target = 0, m_floor = 0, m_dir = 0, m_period = 1, m_wait = 0;
  bit m_run = 0, m_bounce = 0, m_done = 0;
  int n_level, n_target, n_floor, n_dir, n_period, n_wait;
  bit n_run, n_bounce, n_done;

  always_comb begin
    n_level = m_level; n_target = m_target; n_floor = m_floor; n_dir = m_dir;
    n_period = m_period; n_wait = m_wait; n_run = m_run; n_bounce = m_bounce;
    n_done = 1'b0;
    if (abort) begin
      n_level = 0; n_run = 1'b0; n_wait = 0;
    end else if (!m_run) begin
      if (cmd_valid) begin
        n_target = (int'(cmd_target) > N) ? N : int'(cmd_target);
        n_bounce = cmd_bounce && (n_target != 0);
        n_floor  = n_bounce ? 0 : n_target;
        n_period = int'(cmd_div) + 1;
        n_wait   = n_period;
        if (n_target == m_level) begin
          n_done = 1'b1;
        end else begin
          n_run = 1'b1;
          n_dir = (n_target > m_level) ? 1 : -1;
        end
      end
    end else begin
      n_wait = m_wait - 1;
      if (n_wait == 0) begin
        n_wait  = m_period;
        n_level = m_level + m_dir;
        if (m_dir > 0 && n_level == m_target) begin
          if (m_bounce) n_dir = -1;
          else begin n_run = 1'b0; n_done = 1'b1; end
        end else if (m_dir < 0 && n_level == m_floor) begin
          n_done = 1'b1;
          if (m_bounce) n_dir = 1;
          else n_run = 1'b0;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level <= 0; m_target <= 0; m_floor <= 0; m_dir <= 0; m_period <= 1;
      m_wait <= 0; m_run <= 1'b0; m_bounce <= 1'b0; m_done <= 1'b0;
    end else begin
      m_level <= n_level; m_target <= n_target; m_floor <= n_floor; m_dir <= n_dir;
      m_period <= n_period; m_wait <= n_wait; m_run <= n_run; m_bounce <= n_bounce;
      m_done <= n_done;
    end
  end

  // Per-cycle compare, inside the low phase after the driver has settled inputs
  always begin
    @(negedge clk);
    #2;
    chk("m_level", 64'(level), 64'(m_level));
    chk("m_leds", 64'(leds), 64'(bar(m_level)));
    chk("m_busy", 64'(busy), 64'(m_run));
    chk("m_done", 64'(done), 64'(m_done));
    chk("m_ready", 64'(cmd_ready), 64'(!m_run && !abort));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input int t, input bit b, input int d);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", 64'(n < 200), 64'(1));
    cmd_valid  = 1'b1;
    cmd_target = 6'(t);
    cmd_bounce = b;
    cmd_div    = 16'(d);
    tick();
    cmd_valid = 1'b0;
  endtask

  int seq [9] = '{1, 2, 3, 2, 1, 0, 1, 2, 3};
  int dcount;
  bit acc;

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_target = '0; cmd_bounce = 1'b0;
    cmd_div = '0; abort = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_leds", 64'(leds), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(1));

    // One-shot up to 5, one step per cycle
    send_cmd(5, 1'b0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("up_level", 64'(level), 64'(i));
    end
    chk("up_leds", 64'(leds), 64'h1F);
    chk("up_done", 64'(done), 64'(1));
    chk("up_busy", 64'(busy), 64'(0));
    tick();
    chk("up_done_clr", 64'(done), 64'(0));

    // Prescaled down 5 -> 2, one step every 4 cycles
    send_cmd(2, 1'b0, 3);
    dcount = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c <= 12) chk("dn_level", 64'(level), 64'(5 - c / 4));
      if (done) dcount++;
      if (c == 12) chk("dn_done", 64'(done), 64'(1));
    end
    chk("dn_leds", 64'(leds), 64'h3);
    chk("dn_done_cnt", 64'(dcount), 64'(1));

    // Clamp 40 -> 32, then a no-move command
    send_cmd(40, 1'b0, 0);
    for (int i = 0; i < 30; i++) tick();
    chk("clamp_level", 64'(level), 64'(32));
    chk("clamp_leds", 64'(leds), 64'hFFFF_FFFF);
    chk("clamp_done", 64'(done), 64'(1));
    tick();
    send_cmd(32, 1'b0, 0);
    chk("same_done", 64'(done), 64'(1));
    chk("same_level", 64'(level), 64'(32));
    chk("same_busy", 64'(busy), 64'(0));
    tick();
    chk("same_done_clr", 64'(done), 64'(0));

    send_cmd(0, 1'b0, 0);
    for (int i = 0; i < 32; i++) tick();
    chk("zero_level", 64'(level), 64'(0));
    tick();

    // Bounce between 0 and 3
    send_cmd(3, 1'b1, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("bn_level", 64'(level), 64'(seq[i]));
      chk("bn_done", 64'(done), 64'(seq[i] == 0));
      chk("bn_ready", 64'(cmd_ready), 64'(0));
    end
    tick();
    chk("bn_level2", 64'(level), 64'(2));

    // Abort with a command pending: it must not be taken
    abort = 1'b1; cmd_valid = 1'b1; cmd_target = 6'd4; cmd_bounce = 1'b0; cmd_div = '0;
    #1;
    chk("ab_ready", 64'(cmd_ready), 64'(0));
    tick();
    chk("ab_level", 64'(level), 64'(0));
    chk("ab_leds", 64'(leds), 64'(0));
    chk("ab_busy", 64'(busy), 64'(0));
    chk("ab_done", 64'(done), 64'(0));
    abort = 1'b0;
    #1;
    chk("ab_ready_rel", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    chk("ab_accept", 64'(busy), 64'(1));
    tick(); tick();
    chk("ar_level", 64'(level), 64'(2));

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("ar_level0", 64'(level), 64'(0));
    chk("ar_leds0", 64'(leds), 64'(0));
    chk("ar_busy0", 64'(busy), 64'(0));
    chk("ar_ready0", 64'(cmd_ready), 64'(1));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_cmd(2, 1'b0, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("ar_new_level", 64'(level), 64'(2));
    chk("ar_new_done", 64'(done), 64'(1));

    // Random traffic against the model, holding commands until accepted
    acc = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!cmd_valid || acc) begin
        cmd_valid  = ($urandom_range(0, 3) == 0);
        cmd_target = 6'($urandom_range(0, 40));
        cmd_bounce = ($urandom_range(0, 3) == 0);
        cmd_div    = 16'($urandom_range(0, 3));
      end
      abort = ($urandom_range(0, 59) == 0);
      #1;
      acc = cmd_valid && cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
